// File: rtl/sdf_unit_r2.sv
`default_nettype none
// ============================================================================
//  Module   : sdf_unit_r2
//  Purpose  : Radix-2 single-path delay-feedback (SDF) butterfly stage with a
//             parametrised feedback depth. Each block of 2*DEPTH enabled
//             samples yields DEPTH sums followed by DEPTH differences.
//             Sums leave at once; differences wait in the feedback line and
//             drain while the next block's first half fills it.
//  Ports    : clock      - master clock, rising edge
//             reset      - asynchronous, active-high reset
//             idata_en   - input sample valid
//             idata_r/i  - input sample, real/imag (two's complement)
//             odata_en   - output sample valid (idata_en delayed DEPTH+1)
//             odata_sof  - marks the first sum of each block
//             odata_r/i  - registered output sample, real/imag
//  Options  : define SDF_SCALE_EN to round every butterfly sum/difference
//             down by a factor of two ((s + 1) >>> 1) instead of wrapping.
//  Revision : 1.0 - parametrised depth, start-of-block marker, scaling option
// ============================================================================
module sdf_unit_r2 #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic             odata_sof,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i
);

    localparam int                 c_cnt_w = LOG_DEPTH + 1;
    localparam logic [LOG_DEPTH:0] c_half  = c_cnt_w'(DEPTH);
    localparam logic [LOG_DEPTH:0] c_one   = c_cnt_w'(1);

    // Butterfly arithmetic: sub=0 gives x+y, sub=1 gives x-y.
    function automatic logic [WIDTH-1:0] f_bf(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sub
    );
`ifdef SDF_SCALE_EN
        logic signed [WIDTH:0] s;
        // One guard bit keeps the full-precision result before rounding.
        s = sub ? ($signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y}))
                : ($signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y}));
        s = s + $signed(c_cnt_w'(0) | (WIDTH+1)'(1));
        return WIDTH'(s >>> 1);
`else
        return sub ? (x - y) : (x + y);
`endif
    endfunction

    logic [LOG_DEPTH:0] r_cnt;
    logic [DEPTH:0]     r_en_dly;
    logic               r_sof;
    logic [WIDTH-1:0]   r_dly_r [DEPTH];
    logic [WIDTH-1:0]   r_dly_i [DEPTH];

    logic               w_bf_en;
    logic [WIDTH-1:0]   w_a_r;
    logic [WIDTH-1:0]   w_a_i;
    logic [WIDTH-1:0]   w_dly_in_r;
    logic [WIDTH-1:0]   w_dly_in_i;
    logic [WIDTH-1:0]   w_bf_out_r;
    logic [WIDTH-1:0]   w_bf_out_i;

    // Second half of a block: the delay line now holds the first half.
    assign w_bf_en = r_cnt[LOG_DEPTH] & idata_en;
    assign w_a_r   = r_dly_r[DEPTH-1];
    assign w_a_i   = r_dly_i[DEPTH-1];

    // ------------------------------------------------------------------
    // Control: block counter, valid delay line, start-of-block marker.
    // A gap in idata_en clears the counter so a partial block is dropped
    // and the next enabled sample opens a fresh block.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_en_dly <= '0;
            r_sof    <= 1'b0;
        end else begin
            r_cnt    <= idata_en ? (r_cnt + c_one) : '0;
            r_en_dly <= {r_en_dly[DEPTH-1:0], idata_en};
            r_sof    <= idata_en && (r_cnt == c_half);
        end
    end

    assign odata_en  = r_en_dly[DEPTH];
    assign odata_sof = r_sof;

    // ------------------------------------------------------------------
    // Butterfly: first half stores inputs and drains stored differences;
    // second half emits sums and stores differences.
    // ------------------------------------------------------------------
    always_comb begin
        w_dly_in_r = idata_r;
        w_dly_in_i = idata_i;
        w_bf_out_r = w_a_r;
        w_bf_out_i = w_a_i;
        if (w_bf_en) begin
            w_dly_in_r = f_bf(w_a_r, idata_r, 1'b1);
            w_dly_in_i = f_bf(w_a_i, idata_i, 1'b1);
            w_bf_out_r = f_bf(w_a_r, idata_r, 1'b0);
            w_bf_out_i = f_bf(w_a_i, idata_i, 1'b0);
        end
    end

    // Data path is not reset: its contents are meaningless while odata_en=0.
    // The delay line shifts every cycle so differences drain after input ends.
    always_ff @(posedge clock) begin
        r_dly_r[0] <= w_dly_in_r;
        r_dly_i[0] <= w_dly_in_i;
        for (int k = 1; k < DEPTH; k++) begin
            r_dly_r[k] <= r_dly_r[k-1];
            r_dly_i[k] <= r_dly_i[k-1];
        end
        odata_r <= w_bf_out_r;
        odata_i <= w_bf_out_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdf_unit_r2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdf_unit_r2
//  Purpose  : Directed self-checking bench for sdf_unit_r2 (WIDTH=16,
//             DEPTH=4). Golden outputs are hand-computed per block; the
//             SDF_SCALE_EN build selects the halved/rounded golden set.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_sdf_unit_r2;

    logic        clock = 1'b0;
    logic        reset;
    logic        idata_en;
    logic [15:0] idata_r;
    logic [15:0] idata_i;
    logic        odata_en;
    logic        odata_sof;
    logic [15:0] odata_r;
    logic [15:0] odata_i;

    int checks = 0;
    int errors = 0;

    // Stimulus and expected-output queues, one entry per clock tick.
    logic        s_en  [$];
    logic [15:0] s_r   [$];
    logic [15:0] s_i   [$];
    logic        e_en  [$];
    logic        e_sof [$];
    logic [15:0] e_r   [$];
    logic [15:0] e_i   [$];

    // Block inputs: 0=A, 1=B, 2=C (overflow corner).
    int in_r [3][8];
    int in_i [3][8];
    int g_r  [3][8];
    int g_i  [3][8];
    int p_r  [5];
    int gp_r [5];

    sdf_unit_r2 #(.WIDTH(16), .DEPTH(4), .LOG_DEPTH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .idata_en  (idata_en),
        .idata_r   (idata_r),
        .idata_i   (idata_i),
        .odata_en  (odata_en),
        .odata_sof (odata_sof),
        .odata_r   (odata_r),
        .odata_i   (odata_i)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, $signed(got), $signed(want));
        end
    endtask

    task automatic push_in(input logic en, input int r, input int i);
        s_en.push_back(en);
        s_r.push_back(16'(r));
        s_i.push_back(16'(i));
    endtask

    task automatic push_out(input logic en, input logic sof, input int r, input int i);
        e_en.push_back(en);
        e_sof.push_back(sof);
        e_r.push_back(16'(r));
        e_i.push_back(16'(i));
    endtask

    task automatic push_idle(input int n_in, input int n_out);
        for (int k = 0; k < n_in; k++)  push_in(1'b0, 0, 0);
        for (int k = 0; k < n_out; k++) push_out(1'b0, 1'b0, 0, 0);
    endtask

    task automatic push_blk_in(input int b);
        for (int k = 0; k < 8; k++) push_in(1'b1, in_r[b][k], in_i[b][k]);
    endtask

    task automatic push_blk_out(input int b);
        for (int k = 0; k < 8; k++) push_out(1'b1, k == 0, g_r[b][k], g_i[b][k]);
    endtask

    // Each tick: check outputs at the falling edge, then drive the next input.
    task automatic run(input string name);
        logic        een, esof;
        logic [15:0] er, ei;
        int          t;
        t = 0;
        while (s_en.size() > 0 || e_en.size() > 0) begin
            @(negedge clock);
            if (e_en.size() > 0) begin
                een  = e_en.pop_front();
                esof = e_sof.pop_front();
                er   = e_r.pop_front();
                ei   = e_i.pop_front();
                chk($sformatf("%s t%0d odata_en", name, t), {15'd0, odata_en}, {15'd0, een});
                chk($sformatf("%s t%0d odata_sof", name, t), {15'd0, odata_sof}, {15'd0, esof});
                if (een) begin
                    chk($sformatf("%s t%0d odata_r", name, t), odata_r, er);
                    chk($sformatf("%s t%0d odata_i", name, t), odata_i, ei);
                end
            end
            if (s_en.size() > 0) begin
                idata_en = s_en.pop_front();
                idata_r  = s_r.pop_front();
                idata_i  = s_i.pop_front();
            end else begin
                idata_en = 1'b0;
                idata_r  = '0;
                idata_i  = '0;
            end
            t++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_r[0] = '{1, 2, 3, 4, 5, 6, 7, 8};
        in_i[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        in_r[1] = '{10, 20, 30, 40, 1, 2, 3, 4};
        in_i[1] = '{0, 0, 0, 0, 5, 5, 5, 5};
        in_r[2] = '{32767, 0, 0, 0, 1, 0, 0, 0};
        in_i[2] = '{-32768, 0, 0, 0, -1, 0, 0, 0};
        p_r     = '{100, 200, 300, 400, 50};
`ifdef SDF_SCALE_EN
        g_r[0] = '{3, 4, 5, 6, -2, -2, -2, -2};
        g_i[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        g_r[1] = '{6, 11, 17, 22, 5, 9, 14, 18};
        g_i[1] = '{3, 3, 3, 3, -2, -2, -2, -2};
        g_r[2] = '{16384, 0, 0, 0, 16383, 0, 0, 0};
        g_i[2] = '{-16384, 0, 0, 0, -16383, 0, 0, 0};
        gp_r   = '{75, 200, 300, 400, 25};
`else
        g_r[0] = '{6, 8, 10, 12, -4, -4, -4, -4};
        g_i[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        g_r[1] = '{11, 22, 33, 44, 9, 18, 27, 36};
        g_i[1] = '{5, 5, 5, 5, -5, -5, -5, -5};
        g_r[2] = '{-32768, 0, 0, 0, 32766, 0, 0, 0};
        g_i[2] = '{32767, 0, 0, 0, -32767, 0, 0, 0};
        gp_r   = '{150, 200, 300, 400, 50};
`endif

        reset    = 1'b1;
        idata_en = 1'b0;
        idata_r  = '0;
        idata_i  = '0;
        #12;
        chk("reset odata_en", {15'd0, odata_en}, 16'd0);
        chk("reset odata_sof", {15'd0, odata_sof}, 16'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single block: sums appear 5 ticks after the first sample.
        push_blk_in(0);
        push_idle(0, 5); push_blk_out(0); push_idle(0, 2);
        run("single");

        // Overflow corner on both components.
        push_blk_in(2);
        push_idle(0, 5); push_blk_out(2); push_idle(0, 2);
        run("overflow");

        // Three back-to-back blocks: 24 contiguous valid outputs.
        push_blk_in(0); push_blk_in(1); push_blk_in(2);
        push_idle(0, 5); push_blk_out(0); push_blk_out(1); push_blk_out(2); push_idle(0, 2);
        run("b2b");

        // Gap after 5 samples: partial block emits p0+p4, p1, p2, p3, p0-p4,
        // then a fresh block restarts from counter 0.
        for (int k = 0; k < 5; k++) push_in(1'b1, p_r[k], 0);
        push_idle(3, 0);
        push_blk_in(0);
        push_idle(0, 5);
        for (int k = 0; k < 5; k++) push_out(1'b1, k == 0, gp_r[k], 0);
        push_idle(0, 3);
        push_blk_out(0);
        push_idle(0, 2);
        run("gap");

        // Reset arriving with input sample 6 of block B.
        for (int k = 0; k < 6; k++) push_in(1'b1, in_r[1][k], in_i[1][k]);
        push_idle(0, 5);
        push_out(1'b1, 1'b1, g_r[1][0], g_i[1][0]);
        run("rst_pre");
        @(posedge clock);
        #2;
        chk("rst_pre live odata_en", {15'd0, odata_en}, 16'd1);
        chk("rst_pre live odata_r", odata_r, 16'(g_r[1][1]));
        idata_en = 1'b1;
        idata_r  = 16'(in_r[1][6]);
        idata_i  = 16'(in_i[1][6]);
        reset    = 1'b1;
        #1;
        chk("rst async odata_en", {15'd0, odata_en}, 16'd0);
        chk("rst async odata_sof", {15'd0, odata_sof}, 16'd0);
        @(negedge clock);
        idata_en = 1'b0;
        idata_r  = '0;
        idata_i  = '0;
        chk("rst held odata_en", {15'd0, odata_en}, 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        push_idle(3, 8);
        push_blk_in(0);
        push_blk_out(0);
        push_idle(0, 2);
        run("rst_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
